// File: rtl/tmw_window_seq.sv
// Time-measurement-window sequencer: enables RO channels, settles, measures, pulses sample/done.
// Optional completed-window counter is compiled in when TMW_WINDOW_COUNT_EN is defined.
module tmw_window_seq #(
    parameter int WIDTH    = 8,
    parameter int SETTLE_W = 4,
    parameter int CH       = 4,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                continuous_i,
    input  logic                rr_i,
    input  logic [CH-1:0]       ch_mask_i,
    input  logic [SETTLE_W-1:0] settle_cnt_i,
    input  logic [WIDTH-1:0]    max_counts_i,
    output logic [CH-1:0]       ro_en_o,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic [WIDTH-1:0]    win_cnt_o,
    output logic                busy_o,
    output logic                sample_o,
    output logic                done_o,
    output logic [15:0]         win_total_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;

    state_t              r_state;
    logic [CH-1:0]       r_mask;
    logic                r_rr;
    logic [SETTLE_W-1:0] r_settle;
    logic [WIDTH-1:0]    r_max;
    logic [SETTLE_W-1:0] r_set_cnt;
    logic [CH-1:0]       r_ro_en;
    logic [CH_W-1:0]     r_ch_sel;
    logic [WIDTH-1:0]    r_win_cnt;
    logic                r_busy;
    logic                r_sample;
    logic                r_done;
    logic [CH_W-1:0]     w_first_ch;
    logic [CH_W-1:0]     w_next_ch;

    function automatic logic [CH_W-1:0] f_lowest(input logic [CH-1:0] m);
        logic [CH_W-1:0] res;
        logic [CH-1:0]   sh;
        res = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            sh = m >> i;
            if (sh[0]) res = CH_W'(i);
        end
        return res;
    endfunction

    // Next set bit strictly above cur, wrapping; a single-bit mask returns cur itself.
    function automatic logic [CH_W-1:0] f_next(input logic [CH-1:0] m, input logic [CH_W-1:0] cur);
        logic [CH_W-1:0] res;
        logic [CH-1:0]   sh;
        logic            found;
        int              idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= CH; i++) begin
            idx = (int'(cur) + i) % CH;
            sh  = m >> idx;
            if (!found && sh[0]) begin
                res   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [CH-1:0] f_onehot(input logic [CH_W-1:0] sel);
        return CH'(1) << sel;
    endfunction

    assign w_first_ch = f_lowest(ch_mask_i);
    assign w_next_ch  = f_next(r_mask, r_ch_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_rr      <= 1'b0;
            r_settle  <= '0;
            r_max     <= '0;
            r_set_cnt <= '0;
            r_ro_en   <= '0;
            r_ch_sel  <= '0;
            r_win_cnt <= '0;
            r_busy    <= 1'b0;
            r_sample  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            r_done   <= 1'b0;
            if (abort_i) begin
                r_state <= S_IDLE;
                r_ro_en <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i && ch_mask_i != '0) begin
                            r_mask    <= ch_mask_i;
                            r_rr      <= rr_i;
                            r_settle  <= settle_cnt_i;
                            r_max     <= max_counts_i;
                            r_busy    <= 1'b1;
                            r_set_cnt <= '0;
                            r_ch_sel  <= rr_i ? w_first_ch : '0;
                            r_ro_en   <= rr_i ? f_onehot(w_first_ch) : ch_mask_i;
                            if (settle_cnt_i == '0) begin
                                r_state   <= S_MEASURE;
                                r_win_cnt <= '0;
                                r_sample  <= (max_counts_i == '0);
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (r_set_cnt + SETTLE_W'(1) == r_settle) begin
                            r_state   <= S_MEASURE;
                            r_win_cnt <= '0;
                            r_sample  <= (r_max == '0);
                        end else begin
                            r_set_cnt <= r_set_cnt + SETTLE_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        // Stop at max instead of incrementing so the count never wraps.
                        if (r_win_cnt == r_max) begin
                            r_state <= S_DONE;
                            r_ro_en <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIDTH'(1);
                            r_sample  <= (r_win_cnt + WIDTH'(1) == r_max);
                        end
                    end
                    S_DONE: begin
                        if (continuous_i) begin
                            r_set_cnt <= '0;
                            r_ch_sel  <= r_rr ? w_next_ch : '0;
                            r_ro_en   <= r_rr ? f_onehot(w_next_ch) : r_mask;
                            if (r_settle == '0) begin
                                r_state   <= S_MEASURE;
                                r_win_cnt <= '0;
                                r_sample  <= (r_max == '0);
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef TMW_WINDOW_COUNT_EN
    logic [15:0] r_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total <= '0;
        end else if (r_done) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign win_total_o = r_total;
`else
    assign win_total_o = 16'h0;
`endif

    assign ro_en_o   = r_ro_en;
    assign ch_sel_o  = r_ch_sel;
    assign win_cnt_o = r_win_cnt;
    assign busy_o    = r_busy;
    assign sample_o  = r_sample;
    assign done_o    = r_done;

endmodule
